secuenciador_de_melodia: RTL and testbench

//  Melody sequencer directly upstream of the tone generator. Walks a fixed

---
 rtl/secuenciador_de_melodia_pkg.sv | 19 +
 rtl/secuenciador_de_melodia_if.sv | 14 +
 rtl/secuenciador_de_melodia_rom_cumpleanos.sv | 39 +++
 rtl/secuenciador_de_melodia.sv | 89 ++++++++
 tb/tb_secuenciador_de_melodia.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/secuenciador_de_melodia_pkg.sv
// melodia_pkg: note constants, ROM entry layout and sequencer states.
package melodia_pkg;
  localparam int FREQ_W = 10;
  localparam int DUR_W = 4;
  localparam int ENTRY_W = 14;
  localparam int IDX_W = 5;
  localparam logic [FREQ_W-1:0] NOTA_G4 = 10'd392;
  localparam logic [FREQ_W-1:0] NOTA_A4 = 10'd440;
  localparam logic [FREQ_W-1:0] NOTA_B4 = 10'd494;
  localparam logic [FREQ_W-1:0] NOTA_C5 = 10'd523;
  localparam logic [FREQ_W-1:0] NOTA_D5 = 10'd587;
  localparam logic [FREQ_W-1:0] NOTA_E5 = 10'd659;
  localparam logic [FREQ_W-1:0] NOTA_F5 = 10'd698;
  localparam logic [FREQ_W-1:0] NOTA_G5 = 10'd784;
  typedef enum logic [1:0] {REPOSO, SONAR, PAUSA, FIN} estado_t;
  function automatic logic [ENTRY_W-1:0] nota(logic [FREQ_W-1:0] f, logic [DUR_W-1:0] d);
    return {f, d};
  endfunction
endpackage

// File: rtl/secuenciador_de_melodia_if.sv
// secuenciador_de_melodia_if: user controls in, tone-generator drive out.
interface secuenciador_de_melodia_if;
  import melodia_pkg::*;
  logic iniciar;
  logic detener;
  logic repetir;
  logic [FREQ_W-1:0] tono;
  logic sonando;
  logic [IDX_W-1:0] indice_nota;
  logic ocupado;
  logic fin;
  modport master (output iniciar, detener, repetir, input tono, sonando, indice_nota, ocupado, fin);
  modport slave (input iniciar, detener, repetir, output tono, sonando, indice_nota, ocupado, fin);
endinterface

// File: rtl/secuenciador_de_melodia_rom_cumpleanos.sv
// rom_cumpleanos: "Happy Birthday" note table, {freq, dur}; dur=0 ends the song.
module rom_cumpleanos
  import melodia_pkg::*;
(
  input  logic [IDX_W-1:0]   addr_i,
  output logic [ENTRY_W-1:0] entry_o
);
  always_comb begin
    entry_o = '0;
    case (addr_i)
      5'd0:  entry_o = nota(NOTA_G4, 4'd1);
      5'd1:  entry_o = nota(NOTA_G4, 4'd1);
      5'd2:  entry_o = nota(NOTA_A4, 4'd2);
      5'd3:  entry_o = nota(NOTA_G4, 4'd2);
      5'd4:  entry_o = nota(NOTA_C5, 4'd2);
      5'd5:  entry_o = nota(NOTA_B4, 4'd4);
      5'd6:  entry_o = nota(NOTA_G4, 4'd1);
      5'd7:  entry_o = nota(NOTA_G4, 4'd1);
      5'd8:  entry_o = nota(NOTA_A4, 4'd2);
      5'd9:  entry_o = nota(NOTA_G4, 4'd2);
      5'd10: entry_o = nota(NOTA_D5, 4'd2);
      5'd11: entry_o = nota(NOTA_C5, 4'd4);
      5'd12: entry_o = nota(NOTA_G4, 4'd1);
      5'd13: entry_o = nota(NOTA_G4, 4'd1);
      5'd14: entry_o = nota(NOTA_G5, 4'd2);
      5'd15: entry_o = nota(NOTA_E5, 4'd2);
      5'd16: entry_o = nota(NOTA_C5, 4'd2);
      5'd17: entry_o = nota(NOTA_B4, 4'd2);
      5'd18: entry_o = nota(NOTA_A4, 4'd4);
      5'd19: entry_o = nota(NOTA_F5, 4'd1);
      5'd20: entry_o = nota(NOTA_F5, 4'd1);
      5'd21: entry_o = nota(NOTA_E5, 4'd2);
      5'd22: entry_o = nota(NOTA_C5, 4'd2);
      5'd23: entry_o = nota(NOTA_D5, 4'd2);
      5'd24: entry_o = nota(NOTA_C5, 4'd4);
      default: entry_o = '0;
    endcase
  end
endmodule

// File: rtl/secuenciador_de_melodia.sv
// secuenciador_de_melodia: walks the note ROM, timing each note and its trailing gap.
// All outputs are registered from the next state and the ROM entry at the next index.
module secuenciador_de_melodia
  import melodia_pkg::*;
#(
  parameter int CLK_HZ  = 12_000_000,
  parameter int UNIT_MS = 125,
  parameter int GAP_MS  = 20
) (
  input logic clk_periodo,
  input logic rst_n,
  secuenciador_de_melodia_if.slave bus
);
  localparam int CYC_MS = CLK_HZ / 1000;
  localparam int CNT_W = $clog2(15 * UNIT_MS * CYC_MS + 1);
  localparam logic [CNT_W-1:0] LIM_GAP = CNT_W'(GAP_MS * CYC_MS - 1);
  estado_t state_q, state_d, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_d, lim_son;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DUR_W-1:0] dur_q;
  logic [ENTRY_W-1:0] entry;
  logic [FREQ_W-1:0] tono_q, tono_d;
  logic sonando_q, sonando_d, ocupado_q, fin_q;
  rom_cumpleanos u_rom (.addr_i(idx_d), .entry_o(entry));
  assign lim_son = CNT_W'((int'(dur_q) * UNIT_MS - GAP_MS) * CYC_MS - 1);
  always_comb begin
    state_n = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q + 1'b1;
    case (state_q)
      REPOSO: begin
        cnt_d = '0;
        if (bus.iniciar) begin
          state_n = SONAR;
          idx_d = '0;
        end
      end
      SONAR: if (cnt_q == lim_son) begin
        state_n = PAUSA;
        cnt_d = '0;
      end
      PAUSA: if (cnt_q == LIM_GAP) begin
        state_n = SONAR;
        idx_d = idx_q + 1'b1;
        cnt_d = '0;
      end
      default: begin
        state_n = bus.repetir ? SONAR : REPOSO;
        idx_d = '0;
        cnt_d = '0;
      end
    endcase
    if (bus.detener) begin
      state_n = REPOSO;
      idx_d = '0;
      cnt_d = '0;
    end
  end
  // A freshly loaded entry with dur=0 is the end marker: divert to FIN.
  assign state_d = (state_n == SONAR && entry[DUR_W-1:0] == '0) ? FIN : state_n;
  assign tono_d = (state_d == SONAR) ? entry[ENTRY_W-1 -: FREQ_W] : '0;
  assign sonando_d = (state_d == SONAR) && (tono_d != '0);
  always_ff @(posedge clk_periodo or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REPOSO;
      cnt_q <= '0;
      idx_q <= '0;
      dur_q <= '0;
      tono_q <= '0;
      sonando_q <= 1'b0;
      ocupado_q <= 1'b0;
      fin_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      dur_q <= entry[DUR_W-1:0];
      tono_q <= tono_d;
      sonando_q <= sonando_d;
      ocupado_q <= state_d != REPOSO;
      fin_q <= state_d == FIN;
    end
  end
  assign bus.tono = tono_q;
  assign bus.sonando = sonando_q;
  assign bus.indice_nota = idx_q;
  assign bus.ocupado = ocupado_q;
  assign bus.fin = fin_q;
endmodule

// File: tb/tb_secuenciador_de_melodia.sv
// tb_secuenciador_de_melodia: randomized controls checked against a note-list timing model.
module tb_secuenciador_de_melodia;
  localparam int CYC = 4;
  localparam int UNIT = 10;
  localparam int GAP = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int f_ref[25] = '{392, 392, 440, 392, 523, 494, 392, 392, 440, 392, 587, 523,
                    392, 392, 784, 659, 523, 494, 440, 698, 698, 659, 523, 587, 523};
  int d_ref[25] = '{1, 1, 2, 2, 2, 4, 1, 1, 2, 2, 2, 4, 1, 1, 2, 2, 2, 2, 4, 1, 1, 2, 2, 2, 4};
  always #5 clk = ~clk;
  secuenciador_de_melodia_if bus ();
  secuenciador_de_melodia #(.CLK_HZ(4000), .UNIT_MS(UNIT), .GAP_MS(GAP)) dut (
    .clk_periodo(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  function automatic logic [17:0] obs();
    return {bus.tono, bus.sonando, bus.indice_nota, bus.ocupado, bus.fin};
  endfunction
  function automatic logic [17:0] pk(int f, bit s, int i, bit o, bit fn);
    return {10'(f), s, 5'(i), o, fn};
  endfunction
  task automatic test_reset();
    int k;
    repeat (2) @(negedge clk);
    checks++;
    if (obs() !== 18'h0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", obs(), 18'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    bus.iniciar = 1'b1;
    @(negedge clk);
    bus.iniciar = 1'b0;
    k = $urandom_range(2, 30);
    repeat (k) @(negedge clk);
    checks++;
    if (obs() !== pk(392, 1, 0, 1, 0)) begin
      failures++;
      $display("FAIL reset_pre_sonar got=%h exp=%h", obs(), pk(392, 1, 0, 1, 0));
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 18'h0) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", obs(), 18'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_detener();
    int k;
    bus.iniciar = 1'b1;
    bus.detener = 1'b1;
    @(negedge clk);
    bus.iniciar = 1'b0;
    bus.detener = 1'b0;
    checks++;
    if (obs() !== 18'h0) begin
      failures++;
      $display("FAIL detener_vs_iniciar got=%h exp=%h", obs(), 18'h0);
    end
    bus.iniciar = 1'b1;
    @(negedge clk);
    bus.iniciar = 1'b0;
    k = $urandom_range(32, 39);
    repeat (k) @(negedge clk);
    checks++;
    if (obs() !== pk(0, 0, 0, 1, 0)) begin
      failures++;
      $display("FAIL detener_in_pausa_pre got=%h exp=%h", obs(), pk(0, 0, 0, 1, 0));
    end
    bus.detener = 1'b1;
    @(negedge clk);
    bus.detener = 1'b0;
    checks++;
    if (obs() !== 18'h0) begin
      failures++;
      $display("FAIL detener_in_pausa got=%h exp=%h", obs(), 18'h0);
    end
    @(negedge clk);
    checks++;
    if (obs() !== 18'h0) begin
      failures++;
      $display("FAIL detener_stays_reposo got=%h exp=%h", obs(), 18'h0);
    end
  endtask
  task automatic test_song(input bit noise, input bit rep);
    int son;
    bit s;
    logic [17:0] e;
    bus.iniciar = 1'b1;
    for (int i = 0; i < 25; i++) begin
      son = (d_ref[i] * UNIT - GAP) * CYC;
      for (int c = 0; c < son + GAP * CYC; c++) begin
        @(negedge clk);
        s = c < son;
        e = pk(s ? f_ref[i] : 0, s && f_ref[i] != 0, i, 1, 0);
        checks++;
        if (obs() !== e) begin
          failures++;
          $display("FAIL song note=%0d cyc=%0d got=%h exp=%h", i, c, obs(), e);
        end
        bus.iniciar = noise && ($urandom_range(0, 3) == 0);
        bus.repetir = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    checks++;
    if (obs() !== pk(0, 0, 25, 1, 1)) begin
      failures++;
      $display("FAIL song_fin got=%h exp=%h", obs(), pk(0, 0, 25, 1, 1));
    end
    bus.iniciar = 1'b0;
    bus.repetir = rep;
    @(negedge clk);
    checks++;
    if (rep) begin
      if (obs() !== pk(392, 1, 0, 1, 0)) begin
        failures++;
        $display("FAIL song_repeat got=%h exp=%h", obs(), pk(392, 1, 0, 1, 0));
      end
    end else if ({bus.tono, bus.sonando, bus.ocupado, bus.fin} !== 13'h0) begin
      failures++;
      $display("FAIL song_end_reposo got=%h exp=0", {bus.tono, bus.sonando, bus.ocupado, bus.fin});
    end
    if (rep) begin
      bus.detener = 1'b1;
      @(negedge clk);
      bus.detener = 1'b0;
      checks++;
      if (obs() !== 18'h0) begin
        failures++;
        $display("FAIL repeat_detener got=%h exp=%h", obs(), 18'h0);
      end
    end
    bus.repetir = 1'b0;
  endtask
  initial begin
    bus.iniciar = 1'b0;
    bus.detener = 1'b0;
    bus.repetir = 1'b0;
    test_reset();
    test_detener();
    test_song(1'b0, 1'b0);
    @(negedge clk);
    test_song(1'b1, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
